barker_spreader: RTL and testbench

//  802.11b TX stage directly downstream of the LFSR scrambler.
//  - Consumes scrambled bits and differentially encodes them: DBPSK at 1 Mbps, DQPSK at 2 Mbps.
//  - Spreads each symbol with the 11-chip Barker code.
//  - Emits one 2-bit chip phase per accepted transfer to the I/Q mapper.

---
 rtl/barker_spreader.sv | 208 ++++++++++++++++++++
 tb/tb_barker_spreader.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/barker_spreader.sv
// Purpose : 802.11b DBPSK/DQPSK differential encoder + 11-chip Barker spreader (chip0 = BARKER_SEQ MSB).
// Latency : first chip is valid the cycle after the bit that completes a symbol is accepted.
// Backpres: chips hold while chip_ready=0; in_ready drops while spreading unless SYMBOL_PREFETCH_EN
//           adds a one-symbol hold register that keeps chips back-to-back across symbols.
module barker_spreader #(
    parameter logic [10:0] BARKER_SEQ = 11'b10110111000,
    parameter logic [1:0]  PHASE_INIT = 2'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mode,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       bit_in,
    input  logic       in_first,
    input  logic       in_last,
    output logic       chip_valid,
    input  logic       chip_ready,
    output logic [1:0] chip_phase,
    output logic       chip_last
);

    typedef enum logic {S_LOAD, S_SPREAD} state_t;

    state_t     state_q;
    logic [1:0] phase_ref_q;
    logic [3:0] chip_idx_q;
    logic       sym_last_q;
    logic       in_ready_q;
    logic       chip_valid_q;
    logic [1:0] chip_phase_q;
    logic       chip_last_q;

    // Pending DQPSK d0 (a buffered d0 always implies a DQPSK symbol)
    logic       have_d0_q;
    logic       d0_q;
    logic       d0_first_q;
    logic       d0_last_q;

`ifdef SYMBOL_PREFETCH_EN
    logic       hold_vld_q;
    logic [1:0] hold_delta_q;
    logic       hold_first_q;
    logic       hold_last_q;
`endif

    logic       bit_xfer;
    logic       chip_xfer;
    logic       last_chip;
    logic       capture_d0;
    logic       sym_done;
    logic [1:0] sym_delta;
    logic       sym_first;
    logic       sym_last;
    logic       start_sym;
    logic [1:0] sel_delta;
    logic       sel_first;
    logic       sel_last;
    logic [1:0] new_phase_d;
    logic [1:0] first_chip_d;
    logic [3:0] chip_idx_d;
    logic [1:0] chip_phase_d;

    // DQPSK Gray mapping of (d0,d1) to a phase step in quarter turns
    function automatic logic [1:0] dqpsk_delta(input logic d0, input logic d1);
        case ({d0, d1})
            2'b00:   return 2'd0;
            2'b01:   return 2'd1;
            2'b11:   return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

    // +1 chip keeps the symbol phase, -1 chip rotates it by 180 degrees
    function automatic logic [1:0] chip_off(input logic [3:0] idx);
        return BARKER_SEQ[4'd10 - idx] ? 2'd0 : 2'd2;
    endfunction

    // Symbol assembly, next-phase and next-chip computation
    always_comb begin
        bit_xfer   = in_valid & in_ready_q;
        chip_xfer  = chip_valid_q & chip_ready;
        last_chip  = (chip_idx_q == 4'd10);
        capture_d0 = 1'b0;
        sym_done   = 1'b0;
        sym_delta  = 2'd0;
        sym_first  = 1'b0;
        sym_last   = 1'b0;
        if (bit_xfer) begin
            if (have_d0_q) begin
                // d1 completes a DQPSK symbol; mode/first/last on d1 are ignored
                sym_done  = 1'b1;
                sym_delta = dqpsk_delta(d0_q, bit_in);
                sym_first = d0_first_q;
                sym_last  = d0_last_q;
            end else if (!mode) begin
                sym_done  = 1'b1;
                sym_delta = bit_in ? 2'd2 : 2'd0;
                sym_first = in_first;
                sym_last  = in_last;
            end else begin
                capture_d0 = 1'b1;
            end
        end

        start_sym = 1'b0;
        if (state_q == S_LOAD) begin
            start_sym = sym_done;
        end else if (chip_xfer && last_chip) begin
`ifdef SYMBOL_PREFETCH_EN
            start_sym = hold_vld_q | sym_done;
`else
            start_sym = 1'b0;
`endif
        end

`ifdef SYMBOL_PREFETCH_EN
        sel_delta = hold_vld_q ? hold_delta_q : sym_delta;
        sel_first = hold_vld_q ? hold_first_q : sym_first;
        sel_last  = hold_vld_q ? hold_last_q  : sym_last;
`else
        sel_delta = sym_delta;
        sel_first = sym_first;
        sel_last  = sym_last;
`endif
        new_phase_d  = (sel_first ? PHASE_INIT : phase_ref_q) + sel_delta;
        first_chip_d = new_phase_d + chip_off(4'd0);
        chip_idx_d   = chip_idx_q + 4'd1;
        chip_phase_d = phase_ref_q + chip_off(chip_idx_d);
    end

    // LOAD/SPREAD control with registered handshake and chip outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_LOAD;
            phase_ref_q  <= PHASE_INIT;
            chip_idx_q   <= 4'd0;
            sym_last_q   <= 1'b0;
            in_ready_q   <= 1'b0;
            chip_valid_q <= 1'b0;
            chip_phase_q <= 2'd0;
            chip_last_q  <= 1'b0;
            have_d0_q    <= 1'b0;
            d0_q         <= 1'b0;
            d0_first_q   <= 1'b0;
            d0_last_q    <= 1'b0;
`ifdef SYMBOL_PREFETCH_EN
            hold_vld_q   <= 1'b0;
            hold_delta_q <= 2'd0;
            hold_first_q <= 1'b0;
            hold_last_q  <= 1'b0;
`endif
        end else begin
            if (capture_d0) begin
                have_d0_q  <= 1'b1;
                d0_q       <= bit_in;
                d0_first_q <= in_first;
                d0_last_q  <= in_last;
            end else if (sym_done) begin
                have_d0_q  <= 1'b0;
            end

            if (start_sym) begin
                state_q      <= S_SPREAD;
                phase_ref_q  <= new_phase_d;
                chip_idx_q   <= 4'd0;
                sym_last_q   <= sel_last;
                chip_valid_q <= 1'b1;
                chip_phase_q <= first_chip_d;
                chip_last_q  <= 1'b0;
`ifdef SYMBOL_PREFETCH_EN
                hold_vld_q   <= 1'b0;
                in_ready_q   <= 1'b1;
`else
                in_ready_q   <= 1'b0;
`endif
            end else if (state_q == S_LOAD) begin
                in_ready_q   <= 1'b1;
            end else if (chip_xfer && last_chip) begin
                state_q      <= S_LOAD;
                chip_valid_q <= 1'b0;
                chip_last_q  <= 1'b0;
                in_ready_q   <= 1'b1;
            end else begin
                if (chip_xfer) begin
                    chip_idx_q   <= chip_idx_d;
                    chip_phase_q <= chip_phase_d;
                    chip_last_q  <= sym_last_q & (chip_idx_d == 4'd10);
                end
`ifdef SYMBOL_PREFETCH_EN
                if (sym_done) begin
                    hold_vld_q   <= 1'b1;
                    hold_delta_q <= sym_delta;
                    hold_first_q <= sym_first;
                    hold_last_q  <= sym_last;
                    in_ready_q   <= 1'b0;
                end
`endif
            end
        end
    end

    assign in_ready   = in_ready_q;
    assign chip_valid = chip_valid_q;
    assign chip_phase = chip_phase_q;
    assign chip_last  = chip_last_q;

endmodule

// File: tb/tb_barker_spreader.sv
// Directed table-driven bench for barker_spreader: symbol phases, chip sequences,
// stalls, DQPSK corner cases, chip_last, asynchronous reset (prefetch run when enabled).
module tb_barker_spreader;

    logic       clk = 1'b0;
    logic       rst;
    logic       mode;
    logic       in_valid;
    logic       in_ready;
    logic       bit_in;
    logic       in_first;
    logic       in_last;
    logic       chip_valid;
    logic       chip_ready;
    logic [1:0] chip_phase;
    logic       chip_last;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    barker_spreader dut (
        .clk        (clk),
        .rst        (rst),
        .mode       (mode),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .bit_in     (bit_in),
        .in_first   (in_first),
        .in_last    (in_last),
        .chip_valid (chip_valid),
        .chip_ready (chip_ready),
        .chip_phase (chip_phase),
        .chip_last  (chip_last)
    );

    // Barker 10110111000 as phase offsets: +1 -> 0, -1 -> 2
    localparam logic [1:0] OFF [11] = '{2'd0, 2'd2, 2'd0, 2'd0, 2'd2, 2'd0,
                                        2'd0, 2'd0, 2'd2, 2'd2, 2'd2};

    typedef struct {
        logic       m0;     // mode with d0
        logic       m1;     // mode with d1 (DQPSK only)
        logic       b0;
        logic       b1;
        logic       f0;     // in_first with d0
        logic       f1;     // in_first with d1 (must be ignored)
        logic       last;
        int         gap;    // idle cycles between d0 and d1
        logic       stall;  // toggle chip_ready 1010...
        logic [1:0] ph;     // hand-computed symbol phase
    } vec_t;

    vec_t vt [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Present one bit at a negedge once in_ready is high; returns on the negedge after the accept
    task automatic send_bit(input logic m, input logic b, input logic f, input logic l);
        int t = 0;
        while (in_ready !== 1'b1 && t < 60) begin
            @(negedge clk);
            t++;
        end
        if (t >= 60) check("in_ready_timeout", 32'd0, 32'd1);
        mode     = m;
        bit_in   = b;
        in_first = f;
        in_last  = l;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_first = 1'b0;
        in_last  = 1'b0;
        bit_in   = ~b;
        mode     = ~m;
    endtask

    // Drain 11 chips of a symbol with phase ph, optionally stalling every other cycle
    task automatic collect(input string tag, input logic [1:0] ph, input logic stall, input logic last);
        int   i = 0;
        int   t = 0;
        logic tog = 1'b1;
        logic [1:0] e;
        while (i < 11 && t < 100) begin
            chip_ready = stall ? tog : 1'b1;
            tog = ~tog;
            e = ph + OFF[i];
            check({tag, "_valid"}, chip_valid, 1);
            check($sformatf("%s_phase%0d", tag, i), chip_phase, e);
            check($sformatf("%s_last%0d", tag, i), chip_last, (last && i == 10) ? 1 : 0);
`ifndef SYMBOL_PREFETCH_EN
            check({tag, "_rdy_spread"}, in_ready, 0);
`endif
            @(posedge clk);
            if (chip_ready) i++;
            @(negedge clk);
            t++;
        end
        chip_ready = 1'b0;
        if (t >= 100) check({tag, "_chip_timeout"}, 32'd0, 32'd1);
`ifndef SYMBOL_PREFETCH_EN
        check({tag, "_idle_valid"}, chip_valid, 0);
        check({tag, "_idle_rdy"}, in_ready, 1);
`endif
    endtask

    task automatic run_vec(input vec_t v, input int k);
        string tag;
        tag = $sformatf("v%0d", k);
        send_bit(v.m0, v.b0, v.f0, v.last);
        if (v.m0) begin
            for (int g = 0; g < v.gap; g++) begin
                check({tag, "_d0wait_valid"}, chip_valid, 0);
                check({tag, "_d0wait_rdy"}, in_ready, 1);
                @(negedge clk);
            end
            send_bit(v.m1, v.b1, v.f1, 1'b0);
        end
        check({tag, "_latency"}, chip_valid, 1);
        collect(tag, v.ph, v.stall, v.last);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        //        m0    m1    b0    b1    f0    f1    last  gap stall ph
        vt[0]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 2'd2}; // DBPSK first, 1
        vt[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 2'd2}; // 0 keeps phase
        vt[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 2'd0}; // 2+2 wraps
        vt[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0, 2'd1}; // DQPSK first 01
        vt[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b1, 2'd3}; // 11, stalled
        vt[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 2'd2}; // 10: 3+3=2
        vt[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 2'd2}; // 00
        vt[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 2'd0}; // DBPSK 1
        vt[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4, 1'b0, 2'd1}; // d1 arrives late
        vt[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 2'd0}; // first resets ref
        vt[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 2'd2};
        vt[11] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0, 2'd0}; // first on d1 ignored
        vt[12] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 2'd3}; // mode drop on d1 ignored
        vt[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0, 2'd3}; // in_last symbol

        rst        = 1'b1;
        mode       = 1'b0;
        in_valid   = 1'b0;
        bit_in     = 1'b0;
        in_first   = 1'b0;
        in_last    = 1'b0;
        chip_ready = 1'b0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_chip_valid", chip_valid, 0);
        check("rst_chip_phase", chip_phase, 0);
        check("rst_chip_last", chip_last, 0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1);
        check("post_rst_chip_valid", chip_valid, 0);

        for (int k = 0; k < 14; k++) run_vec(vt[k], k);

        // Reset in the middle of spreading: ref 2 before, 0 after
        send_bit(1'b0, 1'b1, 1'b1, 1'b0);
        chip_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
        chip_ready = 1'b0;
        check("mid_chip5_phase", chip_phase, 2'd2 + OFF[5]);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", chip_valid, 0);
        check("mid_rst_phase", chip_phase, 0);
        check("mid_rst_last", chip_last, 0);
        check("mid_rst_rdy", in_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("mid_rel_rdy", in_ready, 1);
        run_vec('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 2'd0}, 100);

        // Reset with only a DQPSK d0 buffered: the half symbol is dropped
        send_bit(1'b1, 1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_vec('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 2'd0}, 101);

`ifdef SYMBOL_PREFETCH_EN
        // Three DBPSK bits back-to-back must give 33 gap-free chips
        begin
            int run = 0;
            int t = 0;
            chip_ready = 1'b1;
            fork
                begin
                    send_bit(1'b0, 1'b1, 1'b1, 1'b0);
                    send_bit(1'b0, 1'b0, 1'b0, 1'b0);
                    send_bit(1'b0, 1'b1, 1'b0, 1'b0);
                end
                begin
                    while (chip_valid !== 1'b1 && t < 60) begin
                        @(negedge clk);
                        t++;
                    end
                    while (chip_valid === 1'b1 && run < 60) begin
                        run++;
                        @(negedge clk);
                    end
                end
            join
            chip_ready = 1'b0;
            check("prefetch_run", run, 33);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
